// File: rtl/wb_pkg.sv
// Shared types for the writeback unit: the write request record and the
// output source selector.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WB_XLEN    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_XLEN-1:0]    data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_LSU
  } wb_src_e;

endpackage

// File: rtl/wb_if.sv
// Writeback bus: issue/ALU/LSU producers on one side, register file write
// port and load scoreboard on the other.
interface wb_if
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
);

  logic                  iss_valid_i;
  logic [REG_ADDR_W-1:0] iss_rd_addr_i;
  logic                  alu_valid_i;
  logic [REG_ADDR_W-1:0] alu_rd_addr_i;
  logic [XLEN-1:0]       alu_rd_data_i;
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [REG_ADDR_W-1:0] lsu_rd_addr_i;
  logic [XLEN-1:0]       lsu_rd_data_i;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]       rd_data_o;
  logic                  rd_wren_o;
  logic [31:0]           pending_o;

  modport master (
    output iss_valid_i, iss_rd_addr_i,
    output alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
    output lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
    input  lsu_ready_o, rd_addr_o, rd_data_o, rd_wren_o, pending_o
  );

  modport slave (
    input  iss_valid_i, iss_rd_addr_i,
    input  alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
    input  lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
    output lsu_ready_o, rd_addr_o, rd_data_o, rd_wren_o, pending_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Load-return buffer: synchronous FIFO of write requests with extra-MSB
// pointers so full and empty are told apart without a counter.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t     mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: merges ALU results and buffered LSU returns into one
// registered register-file write port and tracks loads in flight.
// Optional macro WB_BYPASS_EN lets an LSU return skip the empty buffer.
module wb_unit
  import wb_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int XLEN           = WB_XLEN
) (
  input  logic clk_i,
  input  logic rst_ni,
  wb_if.slave  bus
);

  wb_req_t         alu_req;
  wb_req_t         lsu_req;
  wb_req_t         fifo_head;
  wb_req_t         sel_req;
  wb_src_e         sel;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            lsu_accept;
  logic [XLEN-1:0] alu_data;
  logic [XLEN-1:0] lsu_data;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;
  logic [31:0]     pending_nxt;

  wb_req_t         req_p1;
  logic            vld_p1;
  logic [31:0]     pending_p1;

  assign alu_data = bus.alu_rd_data_i;
  assign lsu_data = bus.lsu_rd_data_i;
  assign alu_req  = '{addr: bus.alu_rd_addr_i, data: alu_data};
  assign lsu_req  = '{addr: bus.lsu_rd_addr_i, data: lsu_data};

  assign bus.lsu_ready_o = !fifo_full;
  assign lsu_accept      = bus.lsu_valid_i && !fifo_full;

  // ALU always wins; the buffer drains only in ALU-idle cycles.
  always_comb begin
    sel      = SRC_NONE;
    sel_req  = '0;
    fifo_pop = 1'b0;
    if (bus.alu_valid_i) begin
      sel     = SRC_ALU;
      sel_req = alu_req;
    end else if (!fifo_empty) begin
      sel      = SRC_FIFO;
      sel_req  = fifo_head;
      fifo_pop = 1'b1;
    end
`ifdef WB_BYPASS_EN
    else if (bus.lsu_valid_i) begin
      sel     = SRC_LSU;
      sel_req = lsu_req;
    end
`endif
  end

  assign fifo_push = lsu_accept && (sel != SRC_LSU);

  wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (lsu_req),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // Scoreboard: a new issue to the same rd outranks the clearing write.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.iss_valid_i) set_mask = 32'b1 << bus.iss_rd_addr_i;
    if (sel == SRC_FIFO || sel == SRC_LSU) clr_mask = 32'b1 << sel_req.addr;
    pending_nxt    = (pending_p1 & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  // ---- stage p1: register file write port and scoreboard ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_p1     <= '0;
      vld_p1     <= 1'b0;
      pending_p1 <= '0;
    end else begin
      req_p1     <= sel_req;
      vld_p1     <= (sel != SRC_NONE) && (sel_req.addr != '0);
      pending_p1 <= pending_nxt;
    end
  end

  assign bus.rd_addr_o = req_p1.addr;
  assign bus.rd_data_o = req_p1.data;
  assign bus.rd_wren_o = vld_p1;
  assign bus.pending_o = pending_p1;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus random traffic
// compared against a queue-based reference model of the writeback rules.
module tb_wb_unit;

  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ent_t        q[$];
  logic [31:0] pend;

  wb_if #(.XLEN(32)) bus ();

  wb_unit #(
    .LSU_FIFO_DEPTH (DEPTH),
    .XLEN           (32)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input bit iv, input logic [4:0] ia,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bus.iss_valid_i   = iv;
    bus.iss_rd_addr_i = ia;
    bus.alu_valid_i   = av;
    bus.alu_rd_addr_i = aa;
    bus.alu_rd_data_i = ad;
    bus.lsu_valid_i   = lv;
    bus.lsu_rd_addr_i = la;
    bus.lsu_rd_data_i = ld;
  endtask

  // One clock cycle: called at a negedge, applies inputs, advances the model,
  // and checks the registered outputs at the following negedge.
  task automatic step(input bit iv, input logic [4:0] ia,
                      input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit          rdy, acc, ew, clr;
    logic [4:0]  ea;
    logic [31:0] ed;
    ent_t        e;
    rdy = (q.size() < DEPTH);
    check("lsu_ready", bus.lsu_ready_o, rdy);
    drive(iv, ia, av, aa, ad, lv, la, ld);
    acc = lv && rdy;
    ew = 1'b0; ea = '0; ed = '0; clr = 1'b0;
    e.a = la; e.d = ld;
    if (av) begin
      ew = (aa != 0); ea = aa; ed = ad;
      if (acc) q.push_back(e);
    end else if (q.size() > 0) begin
      ent_t h;
      h = q.pop_front();
      ew = (h.a != 0); ea = h.a; ed = h.d; clr = 1'b1;
      if (acc) q.push_back(e);
    end else if (BYP && acc) begin
      ew = (la != 0); ea = la; ed = ld; clr = 1'b1;
    end else if (acc) begin
      q.push_back(e);
    end
    if (clr) pend[ea] = 1'b0;
    if (iv) pend[ia] = 1'b1;
    pend[0] = 1'b0;
    @(negedge clk);
    check("rd_wren", bus.rd_wren_o, ew);
    if (ew) begin
      check("rd_addr", bus.rd_addr_o, ea);
      check("rd_data", bus.rd_data_o, ed);
    end
    check("pending", bus.pending_o, pend);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    n_tests = 0;
    n_fail  = 0;
    pend    = '0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 1), 5'($urandom), $urandom_range(0, 1), 5'($urandom), $urandom,
            $urandom_range(0, 1), 5'($urandom), $urandom);
    end
    #1;
    check("rst_wren", bus.rd_wren_o, 0);
    check("rst_pending", bus.pending_o, 0);
    check("rst_ready", bus.lsu_ready_o, 1);
    check("rst_addr", bus.rd_addr_o, 0);
    check("rst_data", bus.rd_data_o, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // ALU write and x0 drop
    step(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("alu_wren", bus.rd_wren_o, 1);
    check("alu_addr", bus.rd_addr_o, 5);
    check("alu_data", bus.rd_data_o, 32'hDEADBEEF);
    step(0, 0, 1, 0, 32'h1234, 0, 0, 0);
    check("x0_wren", bus.rd_wren_o, 0);

    // ALU/LSU collision
    step(0, 0, 1, 3, 1, 1, 7, 2);
    check("col_alu_addr", bus.rd_addr_o, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("col_lsu_addr", bus.rd_addr_o, 7);
    check("col_lsu_data", bus.rd_data_o, 2);
    idle(2);

    // Full buffer under continuous ALU traffic
    k = 0;
    for (int c = 0; c < 7; c++) begin
      bit acc;
      acc = (q.size() < DEPTH) && (k < 5);
      step(0, 0, 1, 5'(20 + c), 32'(c), k < 5, 5'(12 + k), 32'h100 + k);
      if (acc) k++;
    end
    check("full_accepted", k, 4);
    check("full_ready", bus.lsu_ready_o, 0);
    for (int c = 0; c < 10; c++) begin
      bit acc;
      acc = (q.size() < DEPTH) && (k < 5);
      step(0, 0, 0, 0, 0, k < 5, 5'(12 + k), 32'h100 + k);
      if (acc) k++;
    end
    check("full_all_done", q.size(), 0);

    // Scoreboard set, clear, and set-wins
    step(1, 9, 0, 0, 0, 0, 0, 0);
    check("sb_set", bus.pending_o[9], 1);
    step(0, 0, 0, 0, 0, 1, 9, 32'h99);
    if (!BYP) step(0, 0, 0, 0, 0, 0, 0, 0);
    check("sb_clear", bus.pending_o[9], 0);
    step(1, 9, 0, 0, 0, 0, 0, 0);
    if (BYP) step(1, 9, 0, 0, 0, 1, 9, 32'h98);
    else begin
      step(0, 0, 0, 0, 0, 1, 9, 32'h98);
      step(1, 9, 0, 0, 0, 0, 0, 0);
    end
    check("sb_set_wins", bus.pending_o[9], 1);
    idle(2);

    // Bypass latency
    step(0, 0, 0, 0, 0, 1, 4, 32'h55);
    check("byp_n1_wren", bus.rd_wren_o, BYP);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("byp_n2_wren", bus.rd_wren_o, !BYP);
    idle(1);

    // Async reset drops buffered loads
    step(0, 0, 1, 1, 32'hA, 1, 10, 32'hB);
    step(0, 0, 1, 2, 32'hC, 1, 11, 32'hD);
    check("pre_rst_buffered", q.size(), 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wren", bus.rd_wren_o, 0);
    check("arst_ready", bus.lsu_ready_o, 1);
    check("arst_pending", bus.pending_o, 0);
    q.delete();
    pend = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, 5'($urandom),
           $urandom_range(0, 9) < 6, 5'($urandom), $urandom,
           $urandom_range(0, 1), 5'($urandom), $urandom);
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
